// File: rtl/ram_sdp_arbiter_pkg.sv
// Shared defaults for the multi-port arbitrated simple-dual-port RAM block.
package ram_sdp_arbiter_pkg;

    localparam int unsigned DEF_NUM_PORTS   = 4;
    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_ADDR_WIDTH  = 10;
    localparam int unsigned DEF_REG_RD_DATA = 1;
    localparam int unsigned DEF_WRITE_FIRST = 1;
    localparam              RAM_ARCH        = "general";

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one read port, optional output register,
// selectable write-first / read-first behaviour on same-address collisions.
module ram_sdp #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter              ARCH        = "general",
    parameter int unsigned REG_RD_DATA = 1,
    parameter int unsigned WRITE_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    generate
        if (ARCH == "general") begin : g_general
            logic [DATA_WIDTH-1:0] mem_q [DEPTH];
            logic [DATA_WIDTH-1:0] rd_q;
            logic                  bypass_c;

            assign bypass_c = (WRITE_FIRST != 0) && wr_en_i && (wr_addr_i == rd_addr_i);

            // Storage is deliberately never reset.
            always_ff @(posedge clk) begin
                if (wr_en_i) begin
                    mem_q[wr_addr_i] <= wr_data_i;
                end
            end

            always_ff @(posedge clk) begin
                if (rd_en_i) begin
                    rd_q <= bypass_c ? wr_data_i : mem_q[rd_addr_i];
                end
            end

            if (REG_RD_DATA != 0) begin : g_out_reg
                logic [DATA_WIDTH-1:0] out_q;

                always_ff @(posedge clk) begin
                    out_q <= rd_q;
                end

                assign rd_data_o = out_q;
            end else begin : g_no_out_reg
                assign rd_data_o = rd_q;
            end
        end else begin : g_unsupported
            assign rd_data_o = '0;
        end
    endgenerate

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant; the search starts one past
// the last winner and the pointer only moves in cycles that produce a grant.
module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PORTS-1:0]         req_i,
    output logic [NUM_PORTS-1:0]         gnt_c_o,
    output logic [$clog2(NUM_PORTS)-1:0] idx_c_o
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;
    logic [IDX_W-1:0] cand;
    logic             found;

    // First requester found walking forward from last_q+1, wrapping at NUM_PORTS-1.
    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = IDX_W'((32'(last_q) + i) % NUM_PORTS);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                gnt_c_o[cand] = 1'b1;
                idx_c_o       = cand;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (found) begin
            last_d = idx_c_o;
        end
    end

    // Reset to the last port so port 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDX_W'(NUM_PORTS - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ram_sdp_arbiter.sv
// Shares one simple-dual-port RAM among NUM_PORTS requesters with independent
// round-robin write and read arbitration and a tagged read-latency pipeline.
module ram_sdp_arbiter
    import ram_sdp_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = DEF_NUM_PORTS,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned REG_RD_DATA = DEF_REG_RD_DATA,
    parameter int unsigned WRITE_FIRST = DEF_WRITE_FIRST
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             wr_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  wr_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wr_data,
    output logic [NUM_PORTS-1:0]             wr_gnt,
    input  logic [NUM_PORTS-1:0]             rd_req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  rd_addr,
    output logic [NUM_PORTS-1:0]             rd_gnt,
    output logic [NUM_PORTS-1:0]             rd_valid,
    output logic [DATA_WIDTH-1:0]            rd_data
);

    localparam int unsigned LAT   = 1 + REG_RD_DATA;
    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]  wr_gnt_c;
    logic [NUM_PORTS-1:0]  rd_gnt_c;
    logic [IDX_W-1:0]      wr_idx_c;
    logic [IDX_W-1:0]      rd_idx_c;

    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;

    logic [LAT-1:0]        vld_q;
    logic [LAT-1:0]        vld_d;
    logic [IDX_W-1:0]      idx_q [LAT];
    logic [IDX_W-1:0]      idx_d [LAT];

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_wr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (wr_req),
        .gnt_c_o (wr_gnt_c),
        .idx_c_o (wr_idx_c)
    );

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rd_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (rd_req),
        .gnt_c_o (rd_gnt_c),
        .idx_c_o (rd_idx_c)
    );

    // Grants are suppressed while reset is held so nothing transfers into a resetting block.
    assign wr_gnt = wr_gnt_c & {NUM_PORTS{rst_n}};
    assign rd_gnt = rd_gnt_c & {NUM_PORTS{rst_n}};

    assign ram_wr_en   = |wr_gnt;
    assign ram_wr_addr = wr_addr[32'(wr_idx_c) * ADDR_WIDTH +: ADDR_WIDTH];
    assign ram_wr_data = wr_data[32'(wr_idx_c) * DATA_WIDTH +: DATA_WIDTH];
    assign ram_rd_addr = rd_addr[32'(rd_idx_c) * ADDR_WIDTH +: ADDR_WIDTH];

    ram_sdp #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .ARCH        (RAM_ARCH),
        .REG_RD_DATA (REG_RD_DATA),
        .WRITE_FIRST (WRITE_FIRST)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (ram_wr_addr),
        .wr_data_i (ram_wr_data),
        .rd_en_i   (1'b1),
        .rd_addr_i (ram_rd_addr),
        .rd_data_o (rd_data)
    );

    // Tag each read with its port so the response can be steered LAT cycles later.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = |rd_gnt;
        idx_d[0] = rd_idx_c;
        for (int unsigned s = 1; s < LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            idx_d[s] = idx_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned s = 0; s < LAT; s++) begin
                idx_q[s] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int unsigned s = 0; s < LAT; s++) begin
                idx_q[s] <= idx_d[s];
            end
        end
    end

    always_comb begin
        rd_valid = '0;
        if (vld_q[LAT-1]) begin
            rd_valid[idx_q[LAT-1]] = 1'b1;
        end
    end

endmodule
